// File: rtl/alu_seq.sv
// alu_seq: sequential RV32 ALU with single-cycle base ops and iterative unsigned mul/div/rem
// behind valid/ready handshakes on both sides.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [3:0]         op;
    logic [WIDTH-1:0]   y;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   alu_r;
    logic [WIDTH-1:0]   sra;
    logic [WIDTH-1:0]   dsub;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dsh;
    logic [SHW-1:0]     sh;
    logic               alu_e;
    logic               dge;

    always_comb begin
        sh    = in_y[SHW-1:0];
        sra   = $signed(in_x) >>> sh;
        alu_e = in_op >= 4'd14;
        case (in_op)
            4'd0:    alu_r = in_x + in_y;
            4'd1:    alu_r = in_x - in_y;
            4'd2:    alu_r = in_x << sh;
            4'd3:    alu_r = {{(WIDTH-1){1'b0}}, $signed(in_x) < $signed(in_y)};
            4'd4:    alu_r = {{(WIDTH-1){1'b0}}, in_x < in_y};
            4'd5:    alu_r = in_x ^ in_y;
            4'd6:    alu_r = in_x >> sh;
            4'd7:    alu_r = sra;
            4'd8:    alu_r = in_x | in_y;
            4'd9:    alu_r = in_x & in_y;
            default: alu_r = '0;
        endcase
    end

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
    always_comb begin
        msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, y} : '0);
        dsh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        dge    = dsh >= {1'b0, y};
        dsub   = dsh[WIDTH-1:0] - y;
        acc_nx = (op[3:1] == 3'b101) ? {msum, acc[WIDTH-1:1]}
                                     : {dge ? dsub : dsh[WIDTH-1:0], acc[WIDTH-2:0], dge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            y          <= '0;
            cnt        <= '0;
            acc        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op       <= in_op;
                    y        <= in_y;
                    in_ready <= 1'b0;
                    if (in_op >= 4'd10 && in_op <= 4'd13) begin
                        state <= BUSY;
                        cnt   <= CW'(WIDTH);
                        acc   <= {{WIDTH{1'b0}}, in_x};
                        busy  <= 1'b1;
                    end else begin
                        state      <= DONE;
                        out_result <= alu_r;
                        out_err    <= alu_e;
                        out_valid  <= 1'b1;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state      <= DONE;
                        out_result <= op[0] ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
